// File: rtl/async_fifo_pkg.sv
// Shared sizing for the async FIFO read-side gather path.
package async_fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned BEATS_DEF = 4;
    localparam int unsigned WSIZE     = DSIZE_DEF * BEATS_DEF;

    typedef logic [$clog2(BEATS_DEF+1)-1:0] beat_cnt_t;

    function automatic int unsigned cnt_width(input int unsigned beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/async_fifo_rd_outreg.sv
// Single-entry valid/ready output register with a load port.
module async_fifo_rd_outreg
    import async_fifo_pkg::*;
#(
    parameter int unsigned W  = WSIZE,
    parameter int unsigned CW = cnt_width(BEATS_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_beats,
    output logic          free,
    output logic [W-1:0]  m_data,
    output logic [CW-1:0] m_beats,
    output logic          m_valid,
    input  logic          m_ready
);

    assign free = !m_valid || m_ready;

    // A load always wins, so a handshake coinciding with a new word leaves no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_beats <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_beats <= load_beats;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/async_fifo_rd_gather.sv
// Packs BEATS FIFO entries into one valid/ready word; optional partial flush on
// idle timeout when ASYNC_FIFO_RD_TIMEOUT_EN is defined.
module async_fifo_rd_gather
    import async_fifo_pkg::*;
#(
    parameter int unsigned DSIZE   = DSIZE_DEF,
    parameter int unsigned BEATS   = BEATS_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic [DSIZE-1:0]           rdata,
    input  logic                       rempty,
    output logic                       rinc,
    output logic [DSIZE*BEATS-1:0]     m_data,
    output logic [$clog2(BEATS+1)-1:0] m_beats,
    output logic                       m_valid,
    input  logic                       m_ready
);

    localparam int unsigned    CW   = cnt_width(BEATS);
    localparam int unsigned    AW   = DSIZE * (BEATS - 1);
    localparam logic [CW-1:0]  LAST = CW'(BEATS - 1);

    logic [CW-1:0]          cnt;
    logic [AW-1:0]          acc;
    logic                   out_free;
    logic                   complete;
    logic                   flush;
    logic                   load;
    logic [DSIZE*BEATS-1:0] load_data;
    logic [CW-1:0]          load_beats;

    assign rinc     = !rrst && !rempty && (cnt != LAST || out_free);
    assign complete = rinc && (cnt == LAST);
    assign load     = complete || flush;

`ifdef ASYNC_FIFO_RD_TIMEOUT_EN
    localparam int unsigned   IW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic [IW-1:0] idle;

    always_ff @(posedge rclk) begin
        if (rrst || rinc || cnt == '0 || flush) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + IW'(1);
        end
    end

    assign flush = (idle == IDLE_MAX) && (cnt != '0) && out_free && !rinc;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign flush          = 1'b0;
`endif

    // The last lane is never stored: the completing beat goes straight into the output word.
    always_ff @(posedge rclk) begin
        if (rrst || load) begin
            cnt <= '0;
            acc <= '0;
        end else if (rinc) begin
            acc[cnt*DSIZE +: DSIZE] <= rdata;
            cnt                     <= cnt + CW'(1);
        end
    end

    always_comb begin
        load_data  = {{DSIZE{1'b0}}, acc};
        load_beats = cnt;
        if (complete) begin
            load_data  = {rdata, acc};
            load_beats = CW'(BEATS);
        end
    end

    async_fifo_rd_outreg #(
        .W  (DSIZE * BEATS),
        .CW (CW)
    ) u_outreg (
        .clk        (rclk),
        .rst        (rrst),
        .load       (load),
        .load_data  (load_data),
        .load_beats (load_beats),
        .free       (out_free),
        .m_data     (m_data),
        .m_beats    (m_beats),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

endmodule

// File: tb/tb_async_fifo_rd_gather.sv
// Scoreboard bench for async_fifo_rd_gather: a FIFO model feeds the read port,
// a negedge monitor pops expected words on every handshake.
`timescale 1ns/1ps
module tb_async_fifo_rd_gather;
    import async_fifo_pkg::*;

    typedef struct {
        logic [WSIZE-1:0] data;
        beat_cnt_t        beats;
    } exp_t;

    logic             rclk    = 1'b0;
    logic             rrst    = 1'b1;
    logic [7:0]       rdata   = '0;
    logic             rempty  = 1'b1;
    logic             rinc;
    logic [WSIZE-1:0] m_data;
    beat_cnt_t        m_beats;
    logic             m_valid;
    logic             m_ready = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned pops  = 0;
    int unsigned cyc   = 0;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    bit gap_mode    = 0;
    bit rand_empty  = 0;
    bit rand_ready  = 0;
    bit ready_level = 0;

    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic             prev_rst   = 1'b1;
    logic [WSIZE-1:0] prev_data  = '0;
    beat_cnt_t        prev_beats = '0;

    async_fifo_rd_gather #(
        .DSIZE   (8),
        .BEATS   (4),
        .TIMEOUT (16)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_beats (m_beats),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 rclk = ~rclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // FIFO read port and downstream ready, updated shortly after each rising edge.
    initial forever begin
        @(posedge rclk);
        #2;
        cyc++;
        if (fifo_q.size() == 0 || (gap_mode && cyc[0]) ||
            (rand_empty && $urandom_range(0, 3) == 0)) begin
            rempty = 1'b1;
            rdata  = 8'($urandom);
        end else begin
            rempty = 1'b0;
            rdata  = fifo_q[0];
        end
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // FIFO model pop and output monitor; inputs are stable mid-cycle.
    always @(negedge rclk) begin
        if (rempty) begin
            n_cmp++;
            if (rinc) begin
                n_bad++;
                $display("FAIL pop_on_empty: got rinc=1 required 0 at cycle %0d", cyc);
            end
        end else if (rinc) begin
            void'(fifo_q.pop_front());
            pops++;
        end

        if (!rrst && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL word: got %h/%0d required no word", m_data, m_beats);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_data !== e.data || m_beats !== e.beats) begin
                    n_bad++;
                    $display("FAIL word: got %h/%0d required %h/%0d", m_data, m_beats, e.data, e.beats);
                end
            end
        end

        if (!rrst && !prev_rst && prev_valid && !prev_ready) begin
            n_cmp++;
            if (!m_valid || m_data !== prev_data || m_beats !== prev_beats) begin
                n_bad++;
                $display("FAIL hold_stable: got %b/%h/%0d required 1/%h/%0d",
                         m_valid, m_data, m_beats, prev_data, prev_beats);
            end
        end
        prev_valid <= m_valid;
        prev_ready <= m_ready;
        prev_rst   <= rrst;
        prev_data  <= m_data;
        prev_beats <= m_beats;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_t e;
        for (int i = 0; i < 4; i++) fifo_q.push_back(w[i*8 +: 8]);
        e.data  = w;
        e.beats = beat_cnt_t'(4);
        exp_q.push_back(e);
    endtask

    task automatic wait_pops(input int unsigned target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (pops >= target) return;
            @(negedge rclk);
            #1;
        end
        chk(name, 32'(pops), 32'(target));
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) return;
            @(negedge rclk);
            #1;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_pulse();
        @(posedge rclk);
        #2 rrst = 1'b1;
        @(posedge rclk);
        #2 rrst = 1'b0;
    endtask

    initial begin
        int unsigned base;
        bit          seen;

        // Reset held three cycles with data present, then a back-to-back stream.
        push_word(32'h44332211);
        push_word(32'h88776655);
        ready_level = 1;
        @(posedge rclk);
        #3;
        repeat (3) begin
            @(negedge rclk);
            #1;
            chk("reset_rinc", 32'(rinc), 32'd0);
            chk("reset_valid", 32'(m_valid), 32'd0);
            chk("reset_beats", 32'(m_beats), 32'd0);
        end
        @(posedge rclk);
        #2 rrst = 1'b0;
        wait_pops(4, 50, "stream_pop_timeout");
        @(negedge rclk);
        #1;
        chk("latency_valid", 32'(m_valid), 32'd1);
        chk("latency_beats", 32'(m_beats), 32'd4);
        wait_drain(100, "stream_drain");

        // Backpressure: one word held, three more beats accepted, then stall.
        ready_level = 0;
        base = pops;
        push_word(32'h04030201);
        push_word(32'h08070605);
        push_word(32'h0c0b0a09);
        repeat (25) @(negedge rclk);
        #1;
        chk("bp_pops", 32'(pops - base), 32'd7);
        chk("bp_rinc_low", 32'(rinc), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", m_data, 32'h04030201);
        ready_level = 1;
        @(posedge rclk);
        #3;
        chk("bp_release_rinc", 32'(rinc), 32'd1);
        @(posedge rclk);
        #3;
        chk("bp_no_bubble_valid", 32'(m_valid), 32'd1);
        chk("bp_no_bubble_data", m_data, 32'h08070605);
        wait_drain(100, "bp_drain");

        // rempty toggling every other cycle.
        gap_mode = 1;
        push_word(32'hd4c3b2a1);
        push_word(32'h5e4d3c2b);
        wait_drain(200, "gap_drain");
        gap_mode = 0;

        // Reset after two beats: those beats must not leak into the next word.
        base = pops;
        fifo_q.push_back(8'hee);
        fifo_q.push_back(8'hef);
        wait_pops(base + 2, 50, "midreset_pop_timeout");
        reset_pulse();
        @(negedge rclk);
        #1;
        chk("midreset_valid", 32'(m_valid), 32'd0);
        push_word(32'h44434241);
        wait_drain(100, "midreset_drain");

        // Two beats then idle.
        fifo_q.push_back(8'haa);
        fifo_q.push_back(8'hbb);
`ifdef ASYNC_FIFO_RD_TIMEOUT_EN
        begin
            exp_t e;
            e.data  = 32'h0000bbaa;
            e.beats = beat_cnt_t'(2);
            exp_q.push_back(e);
        end
        wait_drain(60, "timeout_flush");
`else
        seen = 0;
        repeat (100) begin
            @(negedge rclk);
            #1;
            if (m_valid) seen = 1;
        end
        chk("no_timeout_flush", 32'(seen), 32'd0);
        reset_pulse();
`endif

        // Random rempty/m_ready over 2000 entries.
        rand_empty = 1;
        rand_ready = 1;
        for (int w = 0; w < 500; w++) push_word($urandom);
        wait_drain(20000, "random_drain");
        rand_empty = 0;
        rand_ready = 0;

        repeat (3) @(negedge rclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
